// File: rtl/fp_pkg.sv
// Shared floating-point definitions: flag positions, operand classes and
// small helpers used by the multiplier and the normalise/round stage.
package fp_pkg;

  localparam int FLG_INX = 0;
  localparam int FLG_UNF = 1;
  localparam int FLG_OVF = 2;
  localparam int FLG_INF = 3;
  localparam int FLG_INV = 4;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_FIN  = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } cls_e;

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN, right-aligned in a wide vector; callers slice it.
  function automatic logic [127:0] qnan(input int exp_w, input int man_w);
    logic [127:0] q;
    q = '0;
    for (int i = 0; i < exp_w; i++) q[man_w + i] = 1'b1;
    q[man_w - 1] = 1'b1;
    return q;
  endfunction

  // Leading zeros of a left-justified vector; 128 when the vector is zero.
  function automatic logic [7:0] lzc(input logic [127:0] v);
    logic [7:0] n;
    n = 8'd128;
    for (int i = 0; i < 128; i++) if (v[i]) n = 8'(127 - i);
    return n;
  endfunction

endpackage

// File: rtl/fp_norm_round.sv
// Combinational normalise, round-to-nearest-even and pack of a raw mantissa
// product; also resolves special classes into their final encodings.
module fp_norm_round
  import fp_pkg::*;
#(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = 1 + EXP_W + MAN_W,
  localparam int PW    = 2 * (MAN_W + 1)
) (
  input  logic                   sign,
  input  logic [1:0]             cls,
  input  logic signed [EXP_W+1:0] e,
  input  logic [PW-1:0]          prod,
  output logic [W-1:0]           res,
  output logic [4:0]             flags
);

  // Headroom so that E minus a full-width shift count never wraps.
  localparam int EW = EXP_W + 10;
  localparam logic [127:0] QNAN = qnan(EXP_W, MAN_W);

  function automatic logic rne_up(input logic lsb, input logic g,
                                  input logic r, input logic s);
    return g & (r | s | lsb);
  endfunction

  logic [7:0]             lz;
  logic [PW-2:0]          m;
  logic [MAN_W-1:0]       frac;
  logic                   g, r, s, up, inx;
  logic [MAN_W:0]         frac_r;
  logic signed [EW-1:0]   e_ext, e_norm, e_rnd;

  always_comb begin
    // Leading one lands at bit PW-1; bits below it are fraction, G, R, sticky.
    lz     = lzc({prod, {(128 - PW){1'b0}}});
    m      = prod[PW-2:0] << lz;
    frac   = m[PW-2 -: MAN_W];
    g      = m[PW-2-MAN_W];
    r      = m[PW-3-MAN_W];
    s      = |m[PW-4-MAN_W:0];
    up     = rne_up(frac[0], g, r, s);
    inx    = g | r | s;
    frac_r = {1'b0, frac} + {{MAN_W{1'b0}}, up};
    e_ext  = EW'(e);
    e_norm = e_ext + EW'(1) - $signed({{(EW-8){1'b0}}, lz});
    e_rnd  = e_norm + $signed({{(EW-1){1'b0}}, frac_r[MAN_W]});

    res   = '0;
    flags = '0;
    case (cls)
      CLS_NAN: begin
        res            = QNAN[W-1:0];
        flags[FLG_INV] = 1'b1;
      end
      CLS_INF: begin
        res            = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        flags[FLG_INF] = 1'b1;
      end
      CLS_ZERO: res = {sign, {(W-1){1'b0}}};
      default: begin
        if (e_rnd >= EW'((1 << EXP_W) - 1)) begin
          res            = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flags[FLG_OVF] = 1'b1;
          flags[FLG_INX] = 1'b1;
          flags[FLG_INF] = 1'b1;
        end else if (e_rnd < EW'(1)) begin
          res            = {sign, {(W-1){1'b0}}};
          flags[FLG_UNF] = 1'b1;
          flags[FLG_INX] = 1'b1;
        end else begin
          res            = {sign, e_rnd[EXP_W-1:0], frac_r[MAN_W-1:0]};
          flags[FLG_INX] = inx;
        end
      end
    endcase
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage IEEE-754 multiplier with a single global advance enable,
// valid/ready handshake and a pass-through tag.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  parameter  int TAG_W = 4,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     i_a,
  input  logic [W-1:0]     i_b,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_vld,
  output logic             i_rdy,
  output logic [W-1:0]     o_res,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_res_vld,
  input  logic             i_res_rdy,
  output logic [4:0]       o_flags,
  output logic             overflow
);

  localparam int EXW  = EXP_W + 2;
  localparam int SW   = MAN_W + 1;
  localparam int BIAS = bias(EXP_W);

  logic adv;
  assign adv   = ~o_res_vld | i_res_rdy;
  assign i_rdy = adv;

  logic [EXP_W-1:0]      ea, eb, eff_a, eff_b;
  logic [MAN_W-1:0]      fa, fb;
  logic                  a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
  cls_e                  cls_in;
  logic signed [EXW-1:0] e_in;

  always_comb begin
    ea     = i_a[W-2:MAN_W];
    eb     = i_b[W-2:MAN_W];
    fa     = i_a[MAN_W-1:0];
    fb     = i_b[MAN_W-1:0];
    a_nan  = (&ea) & (|fa);
    b_nan  = (&eb) & (|fb);
    a_inf  = (&ea) & ~(|fa);
    b_inf  = (&eb) & ~(|fb);
    a_zero = ~(|ea) & ~(|fa);
    b_zero = ~(|eb) & ~(|fb);
    eff_a  = (ea == '0) ? EXP_W'(1) : ea;
    eff_b  = (eb == '0) ? EXP_W'(1) : eb;
    e_in   = $signed({2'b00, eff_a}) + $signed({2'b00, eff_b}) - EXW'(BIAS);
    cls_in = CLS_FIN;
    if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero)) cls_in = CLS_NAN;
    else if (a_inf | b_inf)                                  cls_in = CLS_INF;
    else if (a_zero | b_zero)                                cls_in = CLS_ZERO;
  end

  // S1: unpacked operands, class, sign and biased exponent sum
  logic                  vld_p1, sign_p1;
  cls_e                  cls_p1;
  logic signed [EXW-1:0] e_p1;
  logic [SW-1:0]         sig_a_p1, sig_b_p1;
  logic [TAG_W-1:0]      tag_p1;

  always_ff @(posedge clk) begin
    if (rst)      vld_p1 <= 1'b0;
    else if (adv) vld_p1 <= i_vld;
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      sign_p1  <= i_a[W-1] ^ i_b[W-1];
      cls_p1   <= cls_in;
      e_p1     <= e_in;
      sig_a_p1 <= {|ea, fa};
      sig_b_p1 <= {|eb, fb};
      tag_p1   <= i_tag;
    end
  end

  // S2: full-width mantissa product
  logic                  vld_p2, sign_p2;
  cls_e                  cls_p2;
  logic signed [EXW-1:0] e_p2;
  logic [2*SW-1:0]       prod_p2;
  logic [TAG_W-1:0]      tag_p2;

  always_ff @(posedge clk) begin
    if (rst)      vld_p2 <= 1'b0;
    else if (adv) vld_p2 <= vld_p1;
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      sign_p2 <= sign_p1;
      cls_p2  <= cls_p1;
      e_p2    <= e_p1;
      prod_p2 <= {{SW{1'b0}}, sig_a_p1} * {{SW{1'b0}}, sig_b_p1};
      tag_p2  <= tag_p1;
    end
  end

  // S3: normalise, round, pack into the output register
  logic [W-1:0] nr_res;
  logic [4:0]   nr_flags;

  fp_norm_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_norm_round (
    .sign  (sign_p2),
    .cls   (cls_p2),
    .e     (e_p2),
    .prod  (prod_p2),
    .res   (nr_res),
    .flags (nr_flags)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      o_res_vld <= 1'b0;
      o_res     <= '0;
      o_tag     <= '0;
      o_flags   <= '0;
    end else if (adv) begin
      o_res_vld <= vld_p2;
      o_res     <= nr_res;
      o_tag     <= tag_p2;
      o_flags   <= nr_flags;
    end
  end

  // Legacy single-bit indication of any infinite/overflowing result.
  assign overflow = o_flags[FLG_OVF] | o_flags[FLG_INF];

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe: FP32 and binary16 instances checked
// against an exact-integer reference multiplier.
module tb_fp_mul_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;

  typedef struct {
    bit [31:0] res;
    bit [3:0]  tag;
    bit [4:0]  fl;
  } exp_t;

  exp_t q32[$];
  exp_t q16[$];

  // FP32 instance
  logic        rst32;
  logic [31:0] a32, b32, res32;
  logic [3:0]  tagi32, tago32;
  logic        vld32, rdy32, res_vld32, ovf32;
  logic        res_rdy32 = 1'b1;
  logic [4:0]  flg32;
  logic        rdy_rand32 = 1'b0;
  logic        rdy_cmd32 = 1'b1;

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut32 (
    .clk(clk), .rst(rst32), .i_a(a32), .i_b(b32), .i_tag(tagi32),
    .i_vld(vld32), .i_rdy(rdy32), .o_res(res32), .o_tag(tago32),
    .o_res_vld(res_vld32), .i_res_rdy(res_rdy32), .o_flags(flg32),
    .overflow(ovf32)
  );

  // binary16 instance
  logic        rst16;
  logic [15:0] a16, b16, res16;
  logic [3:0]  tagi16, tago16;
  logic        vld16, rdy16, res_vld16, ovf16;
  logic        res_rdy16 = 1'b1;
  logic [4:0]  flg16;
  logic        done16 = 1'b0;

  fp_mul_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) dut16 (
    .clk(clk), .rst(rst16), .i_a(a16), .i_b(b16), .i_tag(tagi16),
    .i_vld(vld16), .i_rdy(rdy16), .o_res(res16), .o_tag(tago16),
    .o_res_vld(res_vld16), .i_res_rdy(res_rdy16), .o_flags(flg16),
    .overflow(ovf16)
  );

  always @(posedge clk) begin
    #2;
    res_rdy32 = rdy_rand32 ? ($urandom_range(0, 3) != 0) : rdy_cmd32;
    res_rdy16 = ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string name, input bit [31:0] act, input bit [31:0] req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
  endtask

  // Reference: exact integer product, rounded to nearest-even in plain arithmetic.
  function automatic void ref_mul(input int ew, input int mw, input bit [31:0] a,
                                  input bit [31:0] b, output bit [31:0] r,
                                  output bit [4:0] f);
    longint unsigned emax, bs, ea, eb, ma, mb, p, q, rem, half, sgn, mask;
    longint be;
    int msb, sh;
    bit s, inx, an, ai, az, bn, bi, bz;
    emax = (64'd1 << ew) - 1;
    bs   = (64'd1 << (ew - 1)) - 1;
    mask = (64'd1 << mw) - 1;
    ea = (64'(a) >> mw) & emax;  ma = 64'(a) & mask;
    eb = (64'(b) >> mw) & emax;  mb = 64'(b) & mask;
    s   = a[ew+mw] ^ b[ew+mw];
    sgn = 64'(s) << (ew + mw);
    an = (ea == emax) && (ma != 0);  ai = (ea == emax) && (ma == 0);  az = (ea == 0) && (ma == 0);
    bn = (eb == emax) && (mb != 0);  bi = (eb == emax) && (mb == 0);  bz = (eb == 0) && (mb == 0);
    f = '0;
    if (an || bn || (ai && bz) || (bi && az)) begin
      r = 32'((emax << mw) | (64'd1 << (mw - 1)));  f = 5'b10000;  return;
    end
    if (ai || bi) begin r = 32'(sgn | (emax << mw)); f = 5'b01000; return; end
    if (az || bz) begin r = 32'(sgn); return; end
    if (ea == 0) ea = 1; else ma = ma | (64'd1 << mw);
    if (eb == 0) eb = 1; else mb = mb | (64'd1 << mw);
    p = ma * mb;
    msb = 0;
    for (int i = 0; i < 64; i++) if (p[i]) msb = i;
    be = longint'(msb) + longint'(ea) + longint'(eb) - longint'(bs) - 2 * longint'(mw);
    sh = msb - mw;
    inx = 1'b0;
    if (sh > 0) begin
      q    = p >> sh;
      rem  = p & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh - 1);
      inx  = (rem != 0);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q >= (64'd2 << mw)) begin q = q >> 1; be = be + 1; end
    end else q = p << (-sh);
    if (be >= longint'(emax)) begin r = 32'(sgn | (emax << mw)); f = 5'b01101; end
    else if (be < 1) begin r = 32'(sgn); f = 5'b00011; end
    else begin r = 32'(sgn | (64'(be) << mw) | (q & mask)); f = {4'b0, inx}; end
  endfunction

  function automatic bit [31:0] gen(input int ew, input int mw);
    int emax = (1 << ew) - 1;
    int bs   = (1 << (ew - 1)) - 1;
    int e;
    bit [31:0] m, s;
    m = $urandom & ((32'd1 << mw) - 1);
    if ($urandom_range(0, 5) == 0) m = 0;
    case ($urandom_range(0, 7))
      0: e = 0;
      1: e = emax;
      2: e = $urandom_range(0, emax);
      3: e = emax - 1 - $urandom_range(0, 2);
      4: e = $urandom_range(1, 3);
      default: e = $urandom_range(bs - emax / 4, bs + emax / 4);
    endcase
    s = $urandom_range(0, 1);
    return (s << (ew + mw)) | (32'(e) << mw) | m;
  endfunction

  exp_t mon32, mon16;

  always @(negedge clk) begin
    if (!rst32 && res_vld32 && res_rdy32) begin
      check("fp32 result expected", 32'(q32.size() != 0), 1);
      if (q32.size() != 0) begin
        mon32 = q32.pop_front();
        check("fp32 res", res32, mon32.res);
        check("fp32 tag", 32'(tago32), 32'(mon32.tag));
        check("fp32 flags", 32'(flg32), 32'(mon32.fl));
        check("fp32 overflow port", 32'(ovf32), 32'(mon32.fl[2] | mon32.fl[3]));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst16 && res_vld16 && res_rdy16) begin
      check("fp16 result expected", 32'(q16.size() != 0), 1);
      if (q16.size() != 0) begin
        mon16 = q16.pop_front();
        check("fp16 res", 32'(res16), mon16.res);
        check("fp16 tag", 32'(tago16), 32'(mon16.tag));
        check("fp16 flags", 32'(flg16), 32'(mon16.fl));
        check("fp16 overflow port", 32'(ovf16), 32'(mon16.fl[2] | mon16.fl[3]));
      end
    end
  end

  task automatic issue32(input bit [31:0] a, input bit [31:0] b, input exp_t e);
    int n = 0;
    a32 = a; b32 = b; tagi32 = e.tag; vld32 = 1'b1;
    forever begin
      @(negedge clk);
      if (rdy32) break;
      n++;
      if (n > 500) begin
        checks++;
        $display("FAIL fp32 accept timeout: i_rdy stayed 0, required 1");
        break;
      end
    end
    if (n <= 500) q32.push_back(e);
    @(posedge clk); #1;
    vld32 = 1'b0;
  endtask

  task automatic issue32_ref(input bit [31:0] a, input bit [31:0] b, input bit [3:0] tag);
    exp_t e;
    ref_mul(8, 23, a, b, e.res, e.fl);
    e.tag = tag;
    issue32(a, b, e);
  endtask

  task automatic issue16(input bit [15:0] a, input bit [15:0] b, input exp_t e);
    int n = 0;
    a16 = a; b16 = b; tagi16 = e.tag; vld16 = 1'b1;
    forever begin
      @(negedge clk);
      if (rdy16) break;
      n++;
      if (n > 500) begin
        checks++;
        $display("FAIL fp16 accept timeout: i_rdy stayed 0, required 1");
        break;
      end
    end
    if (n <= 500) q16.push_back(e);
    @(posedge clk); #1;
    vld16 = 1'b0;
  endtask

  task automatic drain32(input string name);
    int n = 0;
    while (q32.size() != 0 && n < 2000) begin @(posedge clk); #1; n++; end
    check(name, 32'(q32.size()), 0);
  endtask

  // binary16 stream with random backpressure
  initial begin
    exp_t e;
    bit [31:0] x, y;
    int n;
    rst16 = 1'b1; vld16 = 1'b0; a16 = '0; b16 = '0; tagi16 = '0;
    repeat (3) @(posedge clk);
    #1 rst16 = 1'b0;
    e.res = 32'h0000C000; e.fl = 5'b00000; e.tag = 4'd7;
    issue16(16'h3C00, 16'hC000, e);
    for (int i = 0; i < 400; i++) begin
      x = gen(5, 10); y = gen(5, 10);
      ref_mul(5, 10, x, y, e.res, e.fl);
      e.tag = 4'($urandom_range(0, 15));
      issue16(x[15:0], y[15:0], e);
      if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
    end
    n = 0;
    while (q16.size() != 0 && n < 2000) begin @(posedge clk); #1; n++; end
    check("fp16 drain", 32'(q16.size()), 0);
    done16 = 1'b1;
  end

  localparam int ND = 7;
  bit [31:0] dir_a  [ND] = '{32'h3FC00000, 32'h7F800000, 32'hFF800000, 32'h7F7FFFFF,
                             32'h00800000, 32'h3F800001, 32'h00400000};
  bit [31:0] dir_b  [ND] = '{32'h40000000, 32'h00000000, 32'h40000000, 32'h40000000,
                             32'h3F000000, 32'h3F800001, 32'h40000000};
  bit [31:0] dir_r  [ND] = '{32'h40400000, 32'h7FC00000, 32'hFF800000, 32'h7F800000,
                             32'h00000000, 32'h3F800002, 32'h00800000};
  bit [4:0]  dir_f  [ND] = '{5'b00000, 5'b10000, 5'b01000, 5'b01101,
                             5'b00011, 5'b00001, 5'b00000};
  bit [31:0] bp_b   [5]  = '{32'h3F800000, 32'h40000000, 32'h40400000,
                             32'h40800000, 32'h40A00000};

  initial begin
    exp_t e;
    int n, k, acc, c0;
    rst32 = 1'b1; vld32 = 1'b0; a32 = '0; b32 = '0; tagi32 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset o_res_vld", 32'(res_vld32), 0);
    check("reset o_res", res32, 0);
    check("reset o_tag", 32'(tago32), 0);
    check("reset o_flags", 32'(flg32), 0);
    check("reset overflow", 32'(ovf32), 0);
    rst32 = 1'b0;
    @(posedge clk); #1;
    check("i_rdy after reset", 32'(rdy32), 1);

    // directed vectors; first one also measures latency
    for (int i = 0; i < ND; i++) begin
      e.res = dir_r[i]; e.fl = dir_f[i]; e.tag = 4'(i + 9);
      issue32(dir_a[i], dir_b[i], e);
      if (i == 0) begin
        n = 1;
        while (!res_vld32 && n < 10) begin @(posedge clk); #1; n++; end
        check("latency edges", 32'(n), 3);
      end
      drain32("directed drain");
    end

    // continuous stream: one accept per cycle
    c0 = cyc;
    for (int i = 0; i < 8; i++) issue32_ref(32'h3F800000 + 32'(i << 20), 32'h40000000, 4'(i));
    check("stream cycles", 32'(cyc - c0), 8);
    drain32("stream drain");

    // backpressure: only three entries fit while the output is stalled
    rdy_cmd32 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    k = 1; acc = 0;
    for (int c = 0; c < 8; c++) begin
      if (k <= 5) begin a32 = 32'h40000000; b32 = bp_b[k-1]; tagi32 = 4'(k); vld32 = 1'b1; end
      @(negedge clk);
      if (vld32 && rdy32) begin
        ref_mul(8, 23, a32, b32, e.res, e.fl);
        e.tag = 4'(k);
        q32.push_back(e);
        acc++; k++;
      end
      @(posedge clk); #1;
    end
    vld32 = 1'b0;
    check("bp accepted", 32'(acc), 3);
    check("bp i_rdy stalled", 32'(rdy32), 0);
    check("bp o_tag held", 32'(tago32), 1);
    rdy_cmd32 = 1'b1;
    while (k <= 5) begin issue32_ref(32'h40000000, bp_b[k-1], 4'(k)); k++; end
    drain32("bp drain");

    // reset with the pipe full discards everything in flight
    rdy_cmd32 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    for (int i = 0; i < 3; i++) issue32_ref(32'h40400000, 32'h40400000, 4'(i + 12));
    check("full before reset", 32'(res_vld32), 1);
    rst32 = 1'b1;
    q32.delete();
    @(posedge clk); #1;
    check("mid reset o_res_vld", 32'(res_vld32), 0);
    check("mid reset o_res", res32, 0);
    check("mid reset o_flags", 32'(flg32), 0);
    rst32 = 1'b0;
    rdy_cmd32 = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    check("no stale output", 32'(res_vld32), 0);

    // random operands with random backpressure and bubbles
    rdy_rand32 = 1'b1;
    for (int i = 0; i < 300; i++) begin
      issue32_ref(gen(8, 23), gen(8, 23), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    rdy_rand32 = 1'b0;
    drain32("random drain");

    n = 0;
    while (!done16 && n < 40000) begin @(posedge clk); n++; end
    check("fp16 stream finished", 32'(done16), 1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/fp_mul_pipe.md
# fp_mul_pipe

Parametrised, pipelined IEEE-754 binary multiplier. It succeeds the single-cycle FP32 multiplier in the matrix datapath. It adds configurable exponent and mantissa widths, round-to-nearest-even, correct subnormal inputs, a valid/ready handshake with backpressure, and a pass-through tag so the matrix controller can match results to accumulator slots.

## Interface
- EXP_W, 8, exponent field width
- MAN_W, 23, stored mantissa width (hidden bit excluded); W = 1+EXP_W+MAN_W
- TAG_W, 4, sideband tag width, carried unchanged through the pipe
- clk  in  1  clock; one clock domain
- rst  in  1  reset; synchronous, active-high
- i_a, i_b  in  W  operands
- i_tag  in  TAG_W  sideband tag
- i_vld  in  1  operand valid
- i_rdy  out  1  block can accept; transfer occurs when i_vld & i_rdy
- o_res  out  W  result
- o_tag  out  TAG_W  tag of o_res
- o_res_vld  out  1  result valid
- i_res_rdy  in  1  downstream accepts; transfer occurs when o_res_vld & i_res_rdy
- o_flags  out  5  {invalid, inf_out, overflow, underflow, inexact}, qualified by o_res_vld
- overflow  out  1  = o_flags[2] | o_flags[3] (legacy single-bit flag)

## Operation
- Three stages, one global advance enable: adv = ~o_res_vld | i_res_rdy; i_rdy = adv. All stage registers load only when adv is high. Stage valid bits shift with the data.
- S1 unpack/classify:
  - hidden bit = (exp!=0); effective exponent = max(exp,1).
  - class = NaN / Inf / zero / finite; sign = sa^sb.
  - E = ea+eb-BIAS, held in a signed EXP_W+2 register; BIAS = 2^(EXP_W-1)-1.
- S2: mantissa product, 2*(MAN_W+1) bits, unsigned.
- S3 normalise/round/pack:
  - If the product MSB is set, shift right 1 and E+1. Otherwise shift left by the leading-zero count and E−lzc. This covers subnormal inputs.
  - Round to nearest, ties to even, using guard, round and sticky bits. A mantissa carry-out on rounding increments E.
- Priority of special results, highest first:
  - NaN in, or Inf×0 → canonical quiet NaN {0, all-ones, 1, 0…}, invalid=1.
  - Inf → signed Inf, inf_out=1.
  - Zero → signed zero, no flags.
  - E ≥ 2^EXP_W−1 after rounding → signed Inf, overflow=1, inexact=1, inf_out=1.
  - E < 1 → flush to signed zero, underflow=1, inexact=1. Output is flush-to-zero and never subnormal.
  - Otherwise pack; inexact = guard|round|sticky.
- o_res, o_tag and o_flags hold stable while o_res_vld & ~i_res_rdy.

## Timing
- Latency is 3 cycles from the accepted input to o_res_vld with no stall. Throughput is 1 result per cycle while i_res_rdy=1.
- Reset (registered, evaluated at clk edge): all stage valids, o_res_vld, o_res, o_tag, o_flags and overflow are 0. i_rdy is 1 one cycle after rst deasserts, because it derives from o_res_vld=0.
- Reset mid-operation discards all in-flight entries; no result emerges for them.
- Stall: while o_res_vld=1 and i_res_rdy=0, the whole pipe freezes and i_rdy=0. The pipe holds up to 3 entries, and none are lost or duplicated.
- Bubbles in i_vld propagate as invalid stages; they are not compacted.
- With i_vld=1 and i_res_rdy=1 every cycle, a continuous stream flows with no dead cycles.

## Structure
- Shared package fp_pkg holds:
  - flag bit indices (FLG_INV, FLG_INF, FLG_OVF, FLG_UNF, FLG_INX);
  - class enum (CLS_ZERO, CLS_FIN, CLS_INF, CLS_NAN);
  - functions for BIAS(EXP_W) and the canonical qNaN(EXP_W, MAN_W).
- Sub-module fp_norm_round (combinational): takes the product, E and sign, and returns the packed result and flags. It is reused by the planned FP adder.
- Leading-zero counter is a function in fp_pkg.

## Test plan
- FP32 default, no stall: 0x3FC00000 × 0x40000000 → 0x40400000, flags 0, o_res_vld exactly 3 cycles after acceptance, tag preserved.
- Special cases:
  - 0x7F800000 × 0x00000000 → 0x7FC00000, invalid=1.
  - 0xFF800000 × 0x40000000 → 0xFF800000, inf_out=1.
- Overflow and underflow:
  - 0x7F7FFFFF × 0x40000000 → 0x7F800000 with overflow=1, inexact=1, inf_out=1, overflow port=1.
  - 0x00800000 × 0x3F000000 → 0x00000000 with underflow=1, inexact=1.
- Rounding and subnormals:
  - 0x3F800001 × 0x3F800001 → 0x3F800002, inexact=1.
  - Subnormal 0x00400000 × 0x40000000 → 0x00800000, flags 0.
- Backpressure: hold i_res_rdy=0 and offer 5 ops with tags 1–5. Exactly 3 are accepted, then i_rdy=0. Release, and results appear in tag order 1–5 with none dropped. Assert rst mid-stream and check o_res_vld=0 the next cycle with no stale outputs.
- Parameter sweep with EXP_W=5, MAN_W=10 (binary16), randomised against a reference model: 0x3C00 × 0xC000 → 0xC000, and all flags match.
